// File: rtl/csr_hpm_unit_pkg.sv
// Shared constants and types for the HPM CSR bank: address bases, mhpmevent fields, CSR opcodes.
package csr_hpm_unit_pkg;

  localparam logic [11:0] MhpmcounterBase  = 12'hB03;
  localparam logic [11:0] MhpmcounterhBase = 12'hB83;
  localparam logic [11:0] MhpmeventBase    = 12'h323;
  localparam logic [11:0] HpmcounterBase   = 12'hC03;
  localparam logic [11:0] HpmcounterhBase  = 12'hC83;

  localparam int unsigned EvtOfBit   = 31;
  localparam int unsigned EvtMinhBit = 30;
  localparam int unsigned EvtUinhBit = 29;

  typedef enum logic [1:0] {
    OpNone  = 2'b00,
    OpWrite = 2'b01,
    OpSet   = 2'b10,
    OpClear = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    RegNone,
    RegCnt,
    RegCntH,
    RegEvt,
    RegUCnt,
    RegUCntH
  } hpm_reg_e;

  // Set/clear act on a single bit selected by wdata[4:0] of the pre-write value.
  function automatic logic [31:0] csr_modify(input csr_op_e op, input logic [31:0] old_val,
                                             input logic [31:0] wdata);
    logic [31:0] bit_mask;
    bit_mask = 32'd1 << wdata[4:0];
    case (op)
      OpWrite: return wdata;
      OpSet:   return old_val | bit_mask;
      OpClear: return old_val & ~bit_mask;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_hpm_unit_if.sv
// CSR access bus shared with csrfile: request from the CSR unit, registered response back.
interface csr_hpm_unit_if;
  logic        csr_valid_i;
  logic [11:0] csr_address_i;
  logic [1:0]  csr_opcode_i;
  logic        csr_wr_en_i;
  logic [31:0] csr_data_i;
  logic        hpm_hit_o;
  logic        csr_done_o;
  logic        csr_excp_o;
  logic [31:0] csr_data_o;

  modport master (
    output csr_valid_i, csr_address_i, csr_opcode_i, csr_wr_en_i, csr_data_i,
    input  hpm_hit_o, csr_done_o, csr_excp_o, csr_data_o
  );

  modport slave (
    input  csr_valid_i, csr_address_i, csr_opcode_i, csr_wr_en_i, csr_data_i,
    output hpm_hit_o, csr_done_o, csr_excp_o, csr_data_o
  );
endinterface

// File: rtl/csr_hpm_unit_counter.sv
// One HPM counter with its mhpmevent register and sticky overflow flag.
module csr_hpm_unit_counter
  import csr_hpm_unit_pkg::*;
#(
  parameter int unsigned NUM_EVENTS    = 8,
  parameter int unsigned COUNTER_WIDTH = 48,
  parameter int unsigned INC_WIDTH     = 2
) (
  input  logic                             cpu_clock_i,
  input  logic                             cpu_resetn_i,
  input  logic                             i_priv,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0]  i_events,
  input  logic                             i_wr_lo,
  input  logic                             i_wr_hi,
  input  logic                             i_wr_evt,
  input  logic [31:0]                      i_wdata,
  output logic [63:0]                      o_count,
  output logic [31:0]                      o_evt,
  output logic                             o_of
);

  logic [COUNTER_WIDTH-1:0] r_count;
  logic [COUNTER_WIDTH-1:0] w_count_nxt;
  logic [COUNTER_WIDTH:0]   w_sum;
  logic [7:0]               r_sel;
  logic [7:0]               w_wsel;
  logic                     r_minh;
  logic                     r_uinh;
  logic                     r_of;
  logic                     w_of_nxt;
  logic [INC_WIDTH-1:0]     w_inc;
  logic                     w_en;
  logic                     w_carry;
  logic                     w_wr_hi_eff;

  always_comb begin
    w_inc = '0;
    for (int unsigned e = 0; e < NUM_EVENTS; e++) begin
      if (r_sel == 8'(e + 1)) w_inc = i_events[e*INC_WIDTH +: INC_WIDTH];
    end
  end

  assign w_en        = (r_sel != 8'd0) && !(i_priv && r_minh) && !(!i_priv && r_uinh);
  assign w_sum       = {1'b0, r_count} + {{(COUNTER_WIDTH + 1 - INC_WIDTH){1'b0}}, w_inc};
  assign w_wr_hi_eff = i_wr_hi && (COUNTER_WIDTH > 32);

  // A CSR write to either half wins over the same-cycle increment and cannot overflow.
  always_comb begin
    w_count_nxt = r_count;
    w_carry     = 1'b0;
    if (i_wr_lo) begin
      w_count_nxt = (r_count & ~COUNTER_WIDTH'(64'hFFFF_FFFF)) | COUNTER_WIDTH'(i_wdata);
    end else if (w_wr_hi_eff) begin
      w_count_nxt = (r_count & COUNTER_WIDTH'(64'hFFFF_FFFF)) | COUNTER_WIDTH'({i_wdata, 32'h0});
    end else if (w_en) begin
      w_count_nxt = w_sum[COUNTER_WIDTH-1:0];
      w_carry     = w_sum[COUNTER_WIDTH];
    end
  end

  assign w_wsel   = (32'(i_wdata[7:0]) > NUM_EVENTS) ? 8'd0 : i_wdata[7:0];
  assign w_of_nxt = (i_wr_evt ? i_wdata[EvtOfBit] : r_of) | w_carry;

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      r_count <= '0;
      r_sel   <= '0;
      r_minh  <= 1'b0;
      r_uinh  <= 1'b0;
      r_of    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_of    <= w_of_nxt;
      if (i_wr_evt) begin
        r_sel  <= w_wsel;
        r_minh <= i_wdata[EvtMinhBit];
        r_uinh <= i_wdata[EvtUinhBit];
      end
    end
  end

  assign o_count = 64'(r_count);
  assign o_evt   = {r_of, r_minh, r_uinh, 21'd0, r_sel};
  assign o_of    = r_of;

endmodule

// File: rtl/csr_hpm_unit.sv
// HPM CSR bank: address decode, privilege checks, event pipeline stage, registered response, irq.
module csr_hpm_unit
  import csr_hpm_unit_pkg::*;
#(
  parameter int unsigned NUM_COUNTERS  = 4,
  parameter int unsigned NUM_EVENTS    = 8,
  parameter int unsigned COUNTER_WIDTH = 48,
  parameter int unsigned INC_WIDTH     = 2
) (
  input  logic                            cpu_clock_i,
  input  logic                            cpu_resetn_i,
  csr_hpm_unit_if.slave                   csr_bus,
  input  logic                            priv_i,
  input  logic [NUM_COUNTERS-1:0]         mcounteren_i,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0] events_i,
  output logic                            lcof_irq_o
);

  logic [NUM_EVENTS*INC_WIDTH-1:0] r_events;
  hpm_reg_e                        w_reg;
  logic [NUM_COUNTERS-1:0]         w_sel;
  logic                            w_hit;
  logic                            w_user;
  logic                            w_is_wr;
  logic                            w_excp;
  logic                            w_apply;
  logic [31:0]                     w_old;
  logic [31:0]                     w_new;
  logic [63:0]                     w_count [NUM_COUNTERS];
  logic [31:0]                     w_evt   [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]         w_of;
  logic                            r_hit;
  logic                            r_done;
  logic                            r_excp;
  logic                            r_irq;
  logic [31:0]                     r_data;

  always_comb begin
    w_reg = RegNone;
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      if (csr_bus.csr_address_i == MhpmcounterBase + 12'(i)) begin
        w_reg = RegCnt;   w_sel[i] = 1'b1;
      end else if (csr_bus.csr_address_i == MhpmcounterhBase + 12'(i)) begin
        w_reg = RegCntH;  w_sel[i] = 1'b1;
      end else if (csr_bus.csr_address_i == MhpmeventBase + 12'(i)) begin
        w_reg = RegEvt;   w_sel[i] = 1'b1;
      end else if (csr_bus.csr_address_i == HpmcounterBase + 12'(i)) begin
        w_reg = RegUCnt;  w_sel[i] = 1'b1;
      end else if (csr_bus.csr_address_i == HpmcounterhBase + 12'(i)) begin
        w_reg = RegUCntH; w_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_old = '0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      if (w_sel[i]) begin
        case (w_reg)
          RegCnt,  RegUCnt:  w_old = w_count[i][31:0];
          RegCntH, RegUCntH: w_old = w_count[i][63:32];
          RegEvt:            w_old = w_evt[i];
          default:           w_old = '0;
        endcase
      end
    end
  end

  assign w_hit   = (w_reg != RegNone);
  assign w_user  = (w_reg == RegUCnt) || (w_reg == RegUCntH);
  assign w_is_wr = csr_bus.csr_wr_en_i && (csr_op_e'(csr_bus.csr_opcode_i) != OpNone);
  // User aliases are read-only and gated by mcounteren in U-mode; machine CSRs need M-mode.
  assign w_excp  = csr_bus.csr_valid_i && w_hit &&
                   (w_user ? (w_is_wr || (!priv_i && !(|(w_sel & mcounteren_i)))) : !priv_i);
  assign w_apply = csr_bus.csr_valid_i && w_hit && !w_user && w_is_wr && !w_excp;
  assign w_new   = csr_modify(csr_op_e'(csr_bus.csr_opcode_i), w_old, csr_bus.csr_data_i);

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_cnt
    csr_hpm_unit_counter #(
      .NUM_EVENTS    (NUM_EVENTS),
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .INC_WIDTH     (INC_WIDTH)
    ) u_counter (
      .cpu_clock_i  (cpu_clock_i),
      .cpu_resetn_i (cpu_resetn_i),
      .i_priv       (priv_i),
      .i_events     (r_events),
      .i_wr_lo      (w_apply && w_sel[g] && (w_reg == RegCnt)),
      .i_wr_hi      (w_apply && w_sel[g] && (w_reg == RegCntH)),
      .i_wr_evt     (w_apply && w_sel[g] && (w_reg == RegEvt)),
      .i_wdata      (w_new),
      .o_count      (w_count[g]),
      .o_evt        (w_evt[g]),
      .o_of         (w_of[g])
    );
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      r_events <= '0;
      r_hit    <= 1'b0;
      r_done   <= 1'b0;
      r_excp   <= 1'b0;
      r_data   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_events <= events_i;
      r_done   <= csr_bus.csr_valid_i;
      r_hit    <= csr_bus.csr_valid_i && w_hit;
      r_excp   <= w_excp;
      r_data   <= (csr_bus.csr_valid_i && w_hit && !w_excp) ? w_old : '0;
      r_irq    <= |w_of;
    end
  end

  assign csr_bus.hpm_hit_o  = r_hit;
  assign csr_bus.csr_done_o = r_done;
  assign csr_bus.csr_excp_o = r_excp;
  assign csr_bus.csr_data_o = r_data;
  assign lcof_irq_o         = r_irq;

endmodule
